// File: rtl/pc_fetch_gen_if.sv
// Fetch-side bundle of pc_fetch_gen: redirects and hold from ctrl/ex, the
// instruction-bus request/ack pair and the fetched-PC stream towards id.
// master: the PC generator side. slave: the surrounding pipeline/bus side.
interface pc_fetch_gen_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned HOLD_W = 3
);
  logic              trap_flag_i;
  logic [ADDR_W-1:0] trap_addr_i;
  logic              jump_flag_i;
  logic [ADDR_W-1:0] jump_addr_i;
  logic [HOLD_W-1:0] hold_flag_i;
  logic              fetch_req_o;
  logic [ADDR_W-1:0] fetch_addr_o;
  logic              fetch_ack_i;
  logic [ADDR_W-1:0] pc_o;
  logic              pc_valid_o;
  logic              misalign_o;

  modport master (
    input  trap_flag_i, trap_addr_i, jump_flag_i, jump_addr_i, hold_flag_i, fetch_ack_i,
    output fetch_req_o, fetch_addr_o, pc_o, pc_valid_o, misalign_o
  );

  modport slave (
    output trap_flag_i, trap_addr_i, jump_flag_i, jump_addr_i, hold_flag_i, fetch_ack_i,
    input  fetch_req_o, fetch_addr_o, pc_o, pc_valid_o, misalign_o
  );
endinterface

// File: rtl/pc_fetch_gen.sv
// Program-counter generator / instruction-fetch requester.
// One request in flight; a redirect during an outstanding request is parked in
// a pending register and the in-flight result is discarded on its ack. A
// one-entry buffer keeps a fetched PC while ctrl holds the pipeline.
// Optional feature: define PC_MISALIGN_TRAP_EN to reject misaligned jump
// targets (misalign_o pulses); otherwise jump targets are force-aligned.
module pc_fetch_gen #(
  parameter int unsigned       ADDR_W        = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC     = '0,
  parameter int unsigned       STEP          = 4,
  parameter int unsigned       HOLD_W        = 3,
  parameter int unsigned       HOLD_PC_LEVEL = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  jtag_reset_flag_i,
  pc_fetch_gen_if.master        bus
);

  typedef enum logic [1:0] {StIdle, StReq, StDrop} state_e;

  // Clears the low log2(STEP) address bits.
  localparam logic [ADDR_W-1:0] AlignMask = ~(ADDR_W'(STEP) - ADDR_W'(1));

  state_e            state_q;
  logic              fetch_req_q;
  logic [ADDR_W-1:0] fetch_addr_q;  // in StIdle: the next address to request
  logic [ADDR_W-1:0] pending_q;
  logic              buf_valid_q;
  logic [ADDR_W-1:0] buf_pc_q;
  logic [ADDR_W-1:0] pc_q;
  logic              pc_valid_q;
  logic              misalign_q;

  logic              held;
  logic              jump_take;
  logic              mis_det;
  logic              redir;
  logic [ADDR_W-1:0] tgt;
  logic [ADDR_W-1:0] addr_inc;

  // Redirect filtering and priority: trap beats jump; targets are aligned.
  always_comb begin
    held      = bus.hold_flag_i > HOLD_W'(HOLD_PC_LEVEL);
    addr_inc  = fetch_addr_q + ADDR_W'(STEP);
`ifdef PC_MISALIGN_TRAP_EN
    jump_take = bus.jump_flag_i && ((bus.jump_addr_i & ~AlignMask) == '0);
    mis_det   = bus.jump_flag_i && !jump_take && !bus.trap_flag_i;
`else
    jump_take = bus.jump_flag_i;
    mis_det   = 1'b0;
`endif
    redir     = bus.trap_flag_i || jump_take;
    tgt       = bus.trap_flag_i ? (bus.trap_addr_i & AlignMask)
                                : (bus.jump_addr_i & AlignMask);
  end

  // Fetch FSM, result buffer and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst || jtag_reset_flag_i) begin
      state_q      <= StIdle;
      fetch_req_q  <= 1'b0;
      fetch_addr_q <= RESET_VEC;
      pending_q    <= RESET_VEC;
      buf_valid_q  <= 1'b0;
      buf_pc_q     <= RESET_VEC;
      pc_q         <= RESET_VEC;
      pc_valid_q   <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      pc_valid_q <= 1'b0;
      misalign_q <= mis_det;
      if (redir) buf_valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (!held) begin
            if (buf_valid_q && !redir) begin
              pc_q        <= buf_pc_q;
              pc_valid_q  <= 1'b1;
              buf_valid_q <= 1'b0;
            end
            fetch_req_q <= 1'b1;
            state_q     <= StReq;
          end
          if (redir) fetch_addr_q <= tgt;
        end
        StReq: begin
          if (bus.fetch_ack_i) begin
            if (redir) begin
              fetch_addr_q <= tgt;
            end else begin
              fetch_addr_q <= addr_inc;
              // The buffer is always empty here: it only fills on the way to StIdle.
              if (held) begin
                buf_valid_q <= 1'b1;
                buf_pc_q    <= fetch_addr_q;
              end else begin
                pc_q       <= fetch_addr_q;
                pc_valid_q <= 1'b1;
              end
            end
            if (held) begin
              fetch_req_q <= 1'b0;
              state_q     <= StIdle;
            end
          end else if (redir) begin
            pending_q <= tgt;
            state_q   <= StDrop;
          end
        end
        StDrop: begin
          if (bus.fetch_ack_i) begin
            fetch_addr_q <= redir ? tgt : pending_q;
            fetch_req_q  <= !held;
            state_q      <= held ? StIdle : StReq;
          end else if (redir) begin
            pending_q <= tgt;
          end
        end
        default: begin
          fetch_req_q <= 1'b0;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  assign bus.fetch_req_o  = fetch_req_q;
  assign bus.fetch_addr_o = fetch_addr_q;
  assign bus.pc_o         = pc_q;
  assign bus.pc_valid_o   = pc_valid_q;
  assign bus.misalign_o   = misalign_q;

endmodule

// File: tb/tb_pc_fetch_gen.sv
// Self-checking bench for pc_fetch_gen: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_pc_fetch_gen;

  logic clk;
  logic rst;
  logic jtag;

  pc_fetch_gen_if #(.ADDR_W(32), .HOLD_W(3)) bus ();

  pc_fetch_gen #(
    .ADDR_W(32), .RESET_VEC(32'h0), .STEP(4), .HOLD_W(3), .HOLD_PC_LEVEL(1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .jtag_reset_flag_i(jtag),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: one in-flight request, whether its result is wanted,
  // next/pending addresses and a queue of buffered results.
  bit          m_busy, m_keep, m_valid, m_mis;
  logic [31:0] m_addr, m_pend, m_pc;
  logic [31:0] m_buf[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_update(input bit r, input bit tf, input logic [31:0] ta, input bit jf,
                              input logic [31:0] ja, input logic [2:0] h, input bit ack);
    bit          held, jok, redir;
    logic [31:0] tgt, res;
    if (r) begin
      m_busy = 0; m_keep = 0; m_valid = 0; m_mis = 0;
      m_addr = 0; m_pend = 0; m_pc = 0;
      m_buf.delete();
      return;
    end
    held = (h > 1);
`ifdef PC_MISALIGN_TRAP_EN
    jok   = jf && (ja % 4 == 0);
    m_mis = jf && !jok && !tf;
`else
    jok   = jf;
    m_mis = 0;
`endif
    redir = tf || jok;
    tgt   = tf ? (ta / 4) * 4 : (ja / 4) * 4;
    m_valid = 0;
    if (redir) m_buf.delete();
    if (!m_busy) begin
      if (!held) begin
        if (m_buf.size() > 0) begin
          m_pc = m_buf.pop_front();
          m_valid = 1;
        end
        m_busy = 1;
        m_keep = 1;
      end
      if (redir) m_addr = tgt;
    end else if (ack) begin
      if (m_keep && !redir) begin
        res = m_addr;
        if (held) m_buf.push_back(res);
        else begin
          m_pc = res;
          m_valid = 1;
        end
        m_addr = m_addr + 32'd4;
      end else begin
        m_addr = redir ? tgt : m_pend;
      end
      m_busy = !held;
      m_keep = 1;
    end else if (redir) begin
      m_keep = 0;
      m_pend = tgt;
    end
  endtask

  // One clock: drive inputs at the negedge, advance the model, compare at the next negedge.
  task automatic step(input bit r, input bit jr, input bit tf, input logic [31:0] ta,
                      input bit jf, input logic [31:0] ja, input logic [2:0] h, input bit ack);
    rst = r;
    jtag = jr;
    bus.trap_flag_i = tf;
    bus.trap_addr_i = ta;
    bus.jump_flag_i = jf;
    bus.jump_addr_i = ja;
    bus.hold_flag_i = h;
    bus.fetch_ack_i = ack;
    model_update(r || jr, tf, ta, jf, ja, h, ack);
    @(negedge clk);
    chk("fetch_req", 32'(bus.fetch_req_o), 32'(m_busy));
    chk("fetch_addr", bus.fetch_addr_o, m_addr);
    chk("pc_valid", 32'(bus.pc_valid_o), 32'(m_valid));
    if (m_valid) chk("pc", bus.pc_o, m_pc);
    chk("misalign", 32'(bus.misalign_o), 32'(m_mis));
  endtask

  task automatic idle_step(input bit ack, input logic [2:0] h);
    step(0, 0, 0, 32'h0, 0, 32'h0, h, ack);
  endtask

  int hold_left;
  logic [2:0] h;
  logic [31:0] ja;

  initial begin
    rst = 1; jtag = 0;
    bus.trap_flag_i = 0; bus.trap_addr_i = 0;
    bus.jump_flag_i = 0; bus.jump_addr_i = 0;
    bus.hold_flag_i = 0; bus.fetch_ack_i = 0;
    @(negedge clk);

    // Reset state.
    step(1, 0, 0, 0, 0, 0, 0, 1);
    chk("rst_req", 32'(bus.fetch_req_o), 32'd0);
    chk("rst_addr", bus.fetch_addr_o, 32'h0);
    chk("rst_pc", bus.pc_o, 32'h0);
    chk("rst_valid", 32'(bus.pc_valid_o), 32'd0);

    // First request, then back-to-back acks.
    idle_step(0, 0);
    chk("first_req", 32'(bus.fetch_req_o), 32'd1);
    chk("first_addr", bus.fetch_addr_o, 32'h0);
    idle_step(1, 0);
    chk("b2b_addr4", bus.fetch_addr_o, 32'h4);
    chk("b2b_pc0", bus.pc_o, 32'h0);
    chk("b2b_v0", 32'(bus.pc_valid_o), 32'd1);
    idle_step(1, 0);
    chk("b2b_addr8", bus.fetch_addr_o, 32'h8);
    chk("b2b_pc4", bus.pc_o, 32'h4);

    // Jump while 0x8 is outstanding; ack three cycles later.
    step(0, 0, 0, 0, 1, 32'h100, 0, 0);
    chk("jmp_hold_addr", bus.fetch_addr_o, 32'h8);
    idle_step(0, 0);
    idle_step(0, 0);
    idle_step(1, 0);
    chk("jmp_addr", bus.fetch_addr_o, 32'h100);
    chk("jmp_drop", 32'(bus.pc_valid_o), 32'd0);
    idle_step(1, 0);
    chk("jmp_pc", bus.pc_o, 32'h100);
    chk("jmp_next", bus.fetch_addr_o, 32'h104);

    // Trap and jump together with an ack: trap wins, target aligned, result dropped.
    step(0, 0, 1, 32'h202, 1, 32'h100, 0, 1);
    chk("trap_addr", bus.fetch_addr_o, 32'h200);
    chk("trap_drop", 32'(bus.pc_valid_o), 32'd0);

    // Hold with one buffered result.
    idle_step(1, 3'd2);
    chk("hold_req", 32'(bus.fetch_req_o), 32'd0);
    chk("hold_valid", 32'(bus.pc_valid_o), 32'd0);
    for (int i = 0; i < 4; i++) idle_step(0, 3'd2);
    chk("hold_still_idle", 32'(bus.fetch_req_o), 32'd0);
    idle_step(0, 0);
    chk("rel_valid", 32'(bus.pc_valid_o), 32'd1);
    chk("rel_pc", bus.pc_o, 32'h200);
    chk("rel_addr", bus.fetch_addr_o, 32'h204);
    idle_step(0, 0);
    chk("rel_once", 32'(bus.pc_valid_o), 32'd0);

    // Address wrap.
    step(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    idle_step(1, 0);
    chk("wrap_top", bus.fetch_addr_o, 32'hFFFF_FFFC);
    idle_step(1, 0);
    chk("wrap_zero", bus.fetch_addr_o, 32'h0);
    chk("wrap_pc", bus.pc_o, 32'hFFFF_FFFC);

    // Misaligned jump with ack.
    step(0, 0, 0, 0, 1, 32'h102, 0, 1);
`ifdef PC_MISALIGN_TRAP_EN
    chk("mis_addr", bus.fetch_addr_o, 32'h4);
    chk("mis_pulse", 32'(bus.misalign_o), 32'd1);
`else
    chk("mis_addr", bus.fetch_addr_o, 32'h100);
    chk("mis_pulse", 32'(bus.misalign_o), 32'd0);
`endif

    // JTAG reset mid-transaction, then a late ack.
    step(0, 1, 0, 0, 0, 0, 0, 0);
    chk("jtag_req", 32'(bus.fetch_req_o), 32'd0);
    chk("jtag_addr", bus.fetch_addr_o, 32'h0);
    idle_step(1, 0);

    // Randomized traffic.
    hold_left = 0;
    for (int c = 0; c < 4000; c++) begin
      if (hold_left > 0) hold_left--;
      else if ($urandom_range(0, 15) == 0) hold_left = $urandom_range(1, 6);
      h = (hold_left > 0) ? 3'($urandom_range(2, 7)) : 3'($urandom_range(0, 1));
      ja = $urandom();
      if ($urandom_range(0, 1) == 0) ja[1:0] = 2'b00;
      step($urandom_range(0, 99) == 0, $urandom_range(0, 199) == 0,
           $urandom_range(0, 29) == 0, $urandom(),
           $urandom_range(0, 11) == 0, ja, h, $urandom_range(0, 1) == 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_fetch_gen.md
# pc_fetch_gen

Parametrised program-counter generator and instruction-fetch requester for the core front end. It replaces the free-running PC register with a handshaked fetch port, redirect priority (trap over jump), pending-redirect capture while a fetch is outstanding, and a one-entry result buffer so hold from ctrl never loses a fetched address. It sits between ctrl/ex (redirects, hold) and the instruction bus, and feeds the fetched-PC stream to id.

## Interface
- ADDR_W, 32, PC/address width.
- RESET_VEC, 0, PC value after reset or JTAG reset.
- STEP, 4, sequential increment in bytes; power of two.
- HOLD_W, 3, width of hold_flag_i.
- HOLD_PC_LEVEL, 1; fetch stalls when hold_flag_i > HOLD_PC_LEVEL.

- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- jtag_reset_flag_i  in  1  same effect as rst.
- trap_flag_i  in  1  trap redirect request, single-cycle.
- trap_addr_i  in  ADDR_W  trap target.
- jump_flag_i  in  1  jump/branch redirect request, single-cycle.
- jump_addr_i  in  ADDR_W  jump target.
- hold_flag_i  in  HOLD_W  pipeline hold level from ctrl.
- fetch_req_o  out  1  fetch request to instruction bus.
- fetch_addr_o  out  ADDR_W  fetch address; stable while fetch_req_o=1 and no ack.
- fetch_ack_i  in  1  bus accepted/completed fetch_addr_o this cycle.
- pc_o  out  ADDR_W  PC of the fetched instruction presented to id.
- pc_valid_o  out  1  pc_o valid this cycle.
- misalign_o  out  1  one-cycle pulse: rejected misaligned redirect (macro-dependent).

## Operation
- States: IDLE (nothing outstanding), REQ (request outstanding, result kept), DROP (request outstanding, result discarded).
- Redirect = trap_flag_i | jump_flag_i (after misalign filtering); target = trap_addr_i if trap_flag_i, else jump_addr_i. Trap wins on same cycle.
- IDLE: if not held, assert fetch_req_o with fetch_addr_o = next address → REQ. If redirect, next address = target first.
- REQ, no ack, redirect: target captured in pending register → DROP; fetch_addr_o unchanged.
- REQ, ack, no redirect: fetch_addr_o → result buffer; next address = fetch_addr_o + STEP (modulo 2^ADDR_W); stay REQ if not held and buffer will be free, else IDLE.
- REQ, ack, redirect same cycle: result dropped, next address = target.
- DROP, ack: result dropped, next address = pending (or newer redirect this cycle, latest wins, trap priority) → REQ/IDLE per hold.
- DROP, further redirect without ack: pending overwritten.
- Result buffer (1 entry): presented as pc_o/pc_valid_o when hold_flag_i <= HOLD_PC_LEVEL; held otherwise. New request is not issued while buffer full and held. Any redirect flushes the buffer.
- Trap addresses: low log2(STEP) bits forced to 0 always.

## Timing
- Reset (rst or jtag_reset_flag_i): state IDLE, fetch_req_o=0, fetch_addr_o=RESET_VEC, pc_o=RESET_VEC, pc_valid_o=0, misalign_o=0, buffer and pending empty. Reset mid-transaction abandons it; a late ack is ignored.
- First fetch_req_o=1 one cycle after reset deasserts (if not held).
- All outputs registered. pc_valid_o rises cycle after fetch_ack_i when not held; one pc_valid_o per non-dropped ack.
- Back-to-back: with ack every cycle and no hold, fetch_addr_o advances by STEP each cycle, fetch_req_o stays high.
- Redirect to first fetch_addr_o = target: 1 cycle from IDLE or same-cycle ack; otherwise 1 cycle after the outstanding ack.

## Configuration
- PC_MISALIGN_TRAP_EN defined: jump_addr_i with nonzero low log2(STEP) bits is not taken; misalign_o pulses the next cycle; fetch continues sequentially. Trap on same cycle still taken.
- Undefined: jump target low bits forced to 0 and taken; misalign_o tied 0.

## Test plan
- Reset, ack every cycle, no hold → fetch_addr_o 0x0,0x4,0x8…; pc_o follows one cycle after each ack, pc_valid_o continuous.
- Jump to 0x100 while request to 0x8 outstanding, ack 3 cycles later → 0x8 result dropped (no pc_valid_o), next fetch_addr_o=0x100.
- trap (0x200) and jump (0x100) same cycle as ack → next fetch_addr_o=0x200, buffered result flushed.
- hold_flag_i=2 for 5 cycles with one result buffered → pc_valid_o low, no new request; on release pc_o presented once, fetching resumes at +STEP.
- fetch_addr_o=0xFFFF_FFFC acked → next fetch_addr_o=0x0.
- jump to 0x102 → with PC_MISALIGN_TRAP_EN: misalign_o=1 one cycle, sequential continues; without: fetch_addr_o=0x100.
